fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the nRisc datapath. It owns the 8-bit PC and issues requests to instruction memory over a req/ready handshake. It presents one instruction per cycle on InstrucaoLida with a valid flag, and honours stall and jump/branch redirects from the core. A 1-entry skid buffer absorbs a memory response that arrives while the core is stalled.

---
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit.sv | 209 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//    Instruction-memory request/response bundle between the fetch stage and
//    instruction memory. A transfer happens on a rising clock edge where
//    MemReq=1 and MemReady=1. The requester keeps MemReq and MemAddr steady
//    from the rise of MemReq until that transfer.
//
// Signals
//    MemReq    requester -> memory   request pending
//    MemAddr   requester -> memory   request address
//    MemReady  memory -> requester   response valid this cycle
//    MemData   memory -> requester   instruction returned with MemReady
//
// Modports
//    master    fetch-stage side (drives MemReq/MemAddr)
//    slave     memory side (drives MemReady/MemData)
// ----------------------------------------------------------------------------
interface fetch_unit_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 8
);
   logic               MemReq;
   logic [ADDR_W-1:0]  MemAddr;
   logic               MemReady;
   logic [INSTR_W-1:0] MemData;

   modport master (
      output MemReq,
      output MemAddr,
      input  MemReady,
      input  MemData
   );

   modport slave (
      input  MemReq,
      input  MemAddr,
      output MemReady,
      output MemData
   );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//    Instruction-fetch stage for the nRisc datapath. It owns the PC and
//    requests instructions from instruction memory. It presents one
//    registered instruction per cycle to the core, with a valid flag and the
//    instruction's address. The core can stall it and can redirect it for
//    taken jumps or branches. A single-entry skid buffer holds a memory
//    response that lands while the core is stalled on a valid instruction.
//
// Ports
//    Clock          in   rising-edge clock
//    Reset          in   asynchronous active-low reset
//    Stall          in   core cannot accept an instruction this cycle
//    RedirectValid  in   taken jump/branch this cycle (beats Stall)
//    RedirectAddr   in   redirect target
//    mem            if   instruction-memory bundle (master side)
//    InstrucaoLida  out  registered instruction to the core
//    InstrValid     out  InstrucaoLida is valid
//    PCOut          out  address of InstrucaoLida
//    FetchCount     out  consumed-instruction counter (FETCH_PERF_CNT_EN only)
//    StallCount     out  valid-but-stalled cycle counter (FETCH_PERF_CNT_EN only)
//
// Build option
//    FETCH_PERF_CNT_EN  when defined, adds the two 16-bit wrapping counters
//                       and their ports. When undefined, neither exists.
// ----------------------------------------------------------------------------
module fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Stall,
   input  logic               RedirectValid,
   input  logic [ADDR_W-1:0]  RedirectAddr,
   fetch_unit_if.master       mem,
   output logic [INSTR_W-1:0] InstrucaoLida,
   output logic               InstrValid,
   output logic [ADDR_W-1:0]  PCOut
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        FetchCount,
   output logic [15:0]        StallCount
`endif
);

   // state   | meaning
   // --------+---------------------------------------------------------------
   // IDLE    | just out of reset, no request; moves to FETCH after one cycle
   // FETCH   | request to PC outstanding; responses go to the output register
   // DISCARD | redirected while a request was in flight; waiting to drop the
   //         | stale response (address held for the handshake)
   // FULL    | output held by a stall and skid buffer occupied; no request
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_DISCARD = 2'd2,
      S_FULL    = 2'd3
   } state_t;

   state_t             state_q,     state_d;
   logic [ADDR_W-1:0]  pc_q,        pc_d;
   logic [ADDR_W-1:0]  disc_addr_q, disc_addr_d;
   logic [INSTR_W-1:0] instr_q,     instr_d;
   logic [ADDR_W-1:0]  pc_out_q,    pc_out_d;
   logic               valid_q,     valid_d;
   logic [INSTR_W-1:0] skid_q,      skid_d;
   logic [ADDR_W-1:0]  skid_pc_q,   skid_pc_d;

   logic [ADDR_W-1:0]  pc_inc;
   logic               can_load;

   assign pc_inc   = pc_q + ADDR_W'(1);
   // Output register may take a new instruction if it is empty or being consumed.
   assign can_load = !valid_q || !Stall;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      disc_addr_d = disc_addr_q;
      instr_d     = instr_q;
      pc_out_d    = pc_out_q;
      valid_d     = valid_q;
      skid_d      = skid_q;
      skid_pc_d   = skid_pc_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            if (RedirectValid) begin
               pc_d    = RedirectAddr;
               valid_d = 1'b0;
               if (!mem.MemReady) begin
                  // The in-flight request must still complete at its original
                  // address, so remember it and throw the answer away later.
                  disc_addr_d = pc_q;
                  state_d     = S_DISCARD;
               end
            end else if (mem.MemReady && can_load) begin
               instr_d  = mem.MemData;
               pc_out_d = pc_q;
               valid_d  = 1'b1;
               pc_d     = pc_inc;
            end else if (mem.MemReady) begin
               skid_d    = mem.MemData;
               skid_pc_d = pc_q;
               pc_d      = pc_inc;
               state_d   = S_FULL;
            end else if (valid_q && !Stall) begin
               valid_d = 1'b0;
            end
         end

         S_DISCARD: begin
            valid_d = 1'b0;
            if (RedirectValid) begin
               pc_d = RedirectAddr;
            end
            if (mem.MemReady) begin
               state_d = S_FETCH;
            end
         end

         S_FULL: begin
            if (RedirectValid) begin
               skid_d    = '0;
               skid_pc_d = '0;
               valid_d   = 1'b0;
               pc_d      = RedirectAddr;
               state_d   = S_FETCH;
            end else if (!Stall) begin
               instr_d  = skid_q;
               pc_out_d = skid_pc_q;
               valid_d  = 1'b1;
               state_d  = S_FETCH;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         disc_addr_q <= '0;
         instr_q     <= '0;
         pc_out_q    <= '0;
         valid_q     <= 1'b0;
         skid_q      <= '0;
         skid_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         disc_addr_q <= disc_addr_d;
         instr_q     <= instr_d;
         pc_out_q    <= pc_out_d;
         valid_q     <= valid_d;
         skid_q      <= skid_d;
         skid_pc_q   <= skid_pc_d;
      end
   end

   // The request is decoded from the state register only, so it drops as soon
   // as reset is asserted and an abandoned handshake leaves no trace.
   assign mem.MemReq  = (state_q == S_FETCH) || (state_q == S_DISCARD);
   assign mem.MemAddr = (state_q == S_DISCARD) ? disc_addr_q : pc_q;

   assign InstrucaoLida = instr_q;
   assign InstrValid    = valid_q;
   assign PCOut         = pc_out_q;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_q, fetch_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (valid_q && !Stall) begin
         fetch_cnt_d = fetch_cnt_q + 16'd1;
      end
      if (valid_q && Stall) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign FetchCount = fetch_cnt_q;
   assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [7:0] XK = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stall = 1'b0;
   logic       redir = 1'b0;
   logic [7:0] redir_addr = 8'h00;
   logic       mem_ready = 1'b0;
   logic [7:0] instr;
   logic       valid;
   logic [7:0] pcout;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count;
   logic [15:0] stall_count;
`endif

   fetch_unit_if #(.ADDR_W(8), .INSTR_W(8)) mem_if ();

   assign mem_if.MemReady = mem_ready;
   assign mem_if.MemData  = mem_if.MemAddr ^ XK;

   fetch_unit dut (
      .Clock         (clk),
      .Reset         (rst_n),
      .Stall         (stall),
      .RedirectValid (redir),
      .RedirectAddr  (redir_addr),
      .mem           (mem_if),
      .InstrucaoLida (instr),
      .InstrValid    (valid),
      .PCOut         (pcout)
`ifdef FETCH_PERF_CNT_EN
      ,
      .FetchCount    (fetch_count),
      .StallCount    (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // scoreboard: addresses of instructions the core should see, in order
   logic [7:0] sb_q[$];
   logic [7:0] exp_pc;
   bit         stale;
   logic [7:0] stale_addr;
   bit         hold_next;
   logic [7:0] hold_addr;
   int         exp_fetch_cnt;
   int         exp_stall_cnt;

   typedef struct packed {
      logic       stall;
      logic       ready;
      logic       req;
      logic       valid;
      logic [7:0] pc;
   } vec_t;
   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      sb_q.delete();
      exp_pc        = 8'h00;
      stale         = 1'b0;
      stale_addr    = 8'h00;
      hold_next     = 1'b0;
      hold_addr     = 8'h00;
      exp_fetch_cnt = 0;
      exp_stall_cnt = 0;
   endtask

   // Predict what the coming edge does, using current outputs and inputs.
   task automatic model_pre();
      logic [7:0] a;
      if (valid && !stall) begin
         exp_fetch_cnt++;
         chk("sb_expected_item", (sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            a = sb_q.pop_front();
            chk("sb_pcout", pcout, a);
            chk("sb_instr", instr, a ^ XK);
         end
      end
      if (valid && stall) exp_stall_cnt++;
      if (mem_if.MemReq) begin
         chk("mem_addr", mem_if.MemAddr, stale ? stale_addr : exp_pc);
      end
      hold_next = mem_if.MemReq && !mem_ready;
      hold_addr = mem_if.MemAddr;
      if (redir) begin
         if (mem_if.MemReq) begin
            if (!mem_ready && !stale) begin
               stale      = 1'b1;
               stale_addr = exp_pc;
            end else if (mem_ready) begin
               stale = 1'b0;
            end
         end
         exp_pc = redir_addr;
         sb_q.delete();
      end else if (mem_if.MemReq && mem_ready) begin
         if (stale) stale = 1'b0;
         else begin
            sb_q.push_back(exp_pc);
            exp_pc = exp_pc + 8'd1;
         end
      end
   endtask

   // One cycle: drive at negedge, let the posedge happen, land at next negedge.
   task automatic cyc(input logic s, input logic r, input logic rv, input logic [7:0] ra);
      bit h;
      logic [7:0] ha;
      stall      = s;
      mem_ready  = r;
      redir      = rv;
      redir_addr = ra;
      model_pre();
      h  = hold_next;
      ha = hold_addr;
      @(posedge clk);
      @(negedge clk);
      if (h) begin
         chk("req_held", mem_if.MemReq, 1);
         chk("addr_held", mem_if.MemAddr, ha);
      end
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req", mem_if.MemReq, 0);
      chk("rst_valid", valid, 0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit r, req;
      int wait_cnt;

      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h01};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h02};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h03};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h04};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h05};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h05};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h05};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h05};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h06};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h07};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h07};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h08};

      model_clear();
      repeat (2) @(negedge clk);
      chk("reset_req", mem_if.MemReq, 0);
      chk("reset_valid", valid, 0);
      chk("reset_pcout", pcout, 0);
      chk("reset_instr", instr, 0);
      rst_n = 1'b1;

      // zero-wait memory, no stalls
      chk("idle_req", mem_if.MemReq, 0);
      cyc(0, 1, 0, 8'h00);
      chk("edge1_req", mem_if.MemReq, 1);
      chk("edge1_valid", valid, 0);
      for (int k = 2; k < 14; k++) begin
         cyc(0, 1, 0, 8'h00);
         chk("zw_valid", valid, 1);
         chk("zw_pcout", pcout, k - 2);
      end

      // memory answers every third request cycle
      wait_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         req = mem_if.MemReq;
         r   = req && (wait_cnt == 2);
         cyc(0, r, 0, 8'h00);
         if (req) wait_cnt = r ? 0 : wait_cnt + 1;
         chk("lat_valid", valid, r);
      end

      // stall with a response landing in the skid buffer
      pulse_reset();
      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].stall, tbl[i].ready, 0, 8'h00);
         chk("tbl_req", mem_if.MemReq, tbl[i].req);
         chk("tbl_valid", valid, tbl[i].valid);
         chk("tbl_pcout", pcout, tbl[i].pc);
         if (tbl[i].valid) chk("tbl_instr", instr, tbl[i].pc ^ XK);
      end

      // redirect while the request to 8'h12 is pending
      pulse_reset();
      for (int i = 0; i < 19; i++) cyc(0, 1, 0, 8'h00);
      chk("d_pending_addr", mem_if.MemAddr, 8'h12);
      cyc(0, 0, 0, 8'h00);
      chk("d_bubble", valid, 0);
      cyc(0, 0, 1, 8'h40);
      chk("d_disc_req", mem_if.MemReq, 1);
      chk("d_disc_addr", mem_if.MemAddr, 8'h12);
      chk("d_disc_valid", valid, 0);
      cyc(0, 0, 0, 8'h00);
      chk("d_wait_valid", valid, 0);
      cyc(0, 1, 0, 8'h00);
      chk("d_drop_valid", valid, 0);
      chk("d_new_addr", mem_if.MemAddr, 8'h40);
      cyc(0, 1, 0, 8'h00);
      chk("d_valid40", valid, 1);
      chk("d_pcout40", pcout, 8'h40);

      // redirect out of FULL, redirect with zero-wait data, PC wrap
      cyc(1, 1, 0, 8'h00);
      chk("e_full_req", mem_if.MemReq, 0);
      chk("e_full_hold", pcout, 8'h40);
      cyc(1, 0, 1, 8'h80);
      chk("e_squash_valid", valid, 0);
      chk("e_redir_addr", mem_if.MemAddr, 8'h80);
      cyc(0, 1, 0, 8'h00);
      chk("e_pcout80", pcout, 8'h80);
      cyc(1, 1, 1, 8'hFE);
      chk("e_drop_valid", valid, 0);
      chk("e_addr_fe", mem_if.MemAddr, 8'hFE);
      cyc(0, 1, 0, 8'h00);
      cyc(0, 1, 0, 8'h00);
      chk("e_pcout_ff", pcout, 8'hFF);
      chk("e_instr_ff", instr, 8'h5A);
      chk("e_wrap_addr", mem_if.MemAddr, 8'h00);
      cyc(0, 0, 0, 8'h00);
      mem_ready = 1'b1;
      pulse_reset();
      cyc(0, 1, 0, 8'h00);
      chk("e_late_ready_valid", valid, 0);
      chk("e_refetch_addr", mem_if.MemAddr, 8'h00);
      cyc(0, 1, 0, 8'h00);
      chk("e_refetch_pcout", pcout, 8'h00);
      chk("e_refetch_valid", valid, 1);

      // consumed and stalled-valid cycles for the counters
      for (int i = 0; i < 9; i++) cyc(0, 1, 0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 8'h00);
         chk("stall_hold_pc", pcout, 8'h09);
         chk("stall_hold_valid", valid, 1);
      end
      cyc(0, 0, 0, 8'h00);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, exp_fetch_cnt[15:0]);
      chk("stall_count", stall_count, exp_stall_cnt[15:0]);
      chk("fetch_count_10", fetch_count, 16'd10);
      chk("stall_count_4", stall_count, 16'd4);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
